// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - Execute-stage multiply/divide unit with HI/LO registers
// Single-cycle MULT/MULTU, MTHI/MTLO, and a WIDTH-step restoring divider with stall request.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  input  logic             stallE,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_stall,
  output logic             div_busy
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam int         CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] dvnd_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;

  logic             is_div;
  logic             sdiv;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [2*WIDTH-1:0] a_sx;
  logic [2*WIDTH-1:0] b_sx;
  logic [2*WIDTH-1:0] a_zx;
  logic [2*WIDTH-1:0] b_zx;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;

  assign is_div = (opE == OP_DIV) || (opE == OP_DIVU);
  assign sdiv   = (opE == OP_DIV);
  assign a_abs  = (sdiv && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign b_abs  = (sdiv && srcbE[WIDTH-1]) ? -srcbE : srcbE;

  // Low 2W bits of a product of extended operands equal the signed/unsigned product.
  assign a_sx   = {{WIDTH{srcaE[WIDTH-1]}}, srcaE};
  assign b_sx   = {{WIDTH{srcbE[WIDTH-1]}}, srcbE};
  assign a_zx   = {{WIDTH{1'b0}}, srcaE};
  assign b_zx   = {{WIDTH{1'b0}}, srcbE};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_shift[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    quo_fix = neg_quo_q ? -quo_d : quo_d;
    rem_fix = neg_rem_q ? -rem_d : rem_d;
  end

  // A flush drops the request immediately so the hazard unit can squash the divide.
  assign div_stall = ~flushE & (((state_q == S_IDLE) & is_div) | (state_q == S_RUN));
  assign div_busy  = busy_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      dvnd_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div && !flushE) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= a_abs;
            dvsr_q    <= b_abs;
            dvnd_q    <= srcaE;
            neg_quo_q <= sdiv && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            neg_rem_q <= sdiv && srcaE[WIDTH-1];
            dz_q      <= (srcbE == '0);
          end else if (!flushE && !stallE) begin
            case (opE)
              OP_MULT:  {hi_q, lo_q} <= prod_s;
              OP_MULTU: {hi_q, lo_q} <= prod_u;
              OP_MTHI:  hi_q <= srcaE;
              OP_MTLO:  lo_q <= srcaE;
              default:  ;
            endcase
          end
        end
        S_RUN: begin
          if (flushE) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              count_q <= '0;
              hi_q    <= dz_q ? dvnd_q : rem_fix;
              lo_q    <= dz_q ? '1 : quo_fix;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed bench for hilo_muldiv against an arithmetic reference model
module tb_hilo_muldiv;

  logic        clk;
  logic        rst;
  logic [2:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        stallE;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_stall;
  logic        div_busy;

  int n_checks = 0;
  int n_errors = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .opE       (opE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .flushE    (flushE),
    .stallE    (stallE),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .div_stall (div_stall),
    .div_busy  (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_div_op(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4);
  endfunction

  function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // Reference: result known up front, divide latency modelled as a countdown of WIDTH edges.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_prod;
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else if (m_run) begin
      if (flushE) begin
        m_run <= 1'b0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
        end
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (is_div_op(opE) && !flushE) begin
      m_run  <= 1'b1;
      m_left <= 32;
      m_pend <= div_ref(opE == 3'd3, srcaE, srcbE);
    end else if (!flushE && !stallE) begin
      case (opE)
        3'd1: begin
          m_prod = 64'(longint'($signed(srcaE)) * longint'($signed(srcbE)));
          m_hi <= m_prod[63:32];
          m_lo <= m_prod[31:0];
        end
        3'd2: begin
          m_prod = {32'd0, srcaE} * {32'd0, srcbE};
          m_hi <= m_prod[63:32];
          m_lo <= m_prod[31:0];
        end
        3'd5: m_hi <= srcaE;
        3'd6: m_lo <= srcaE;
        default: ;
      endcase
    end
  end

  logic exp_stall;
  always @(negedge clk) begin
    exp_stall = !flushE && ((!m_run && !m_done && is_div_op(opE)) || m_run);
    check("model_hi", hi_o, m_hi);
    check("model_lo", lo_o, m_lo);
    check("model_stall", 32'(div_stall), 32'(exp_stall));
    check("model_busy", 32'(div_busy), 32'(m_run));
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic st);
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    flushE = fl;
    stallE = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after an edge; returns in the DONE cycle with the stall-cycle count.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
    drive(op, a, b, 1'b0, 1'b0);
    #1;
    cycles = 0;
    while (div_stall && cycles < 100) begin
      cycles++;
      @(posedge clk);
      #2;
    end
  endtask

  int cyc;

  initial begin
    rst = 1'b0;
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    check("reset_busy", 32'(div_busy), 32'd0);
    check("reset_stall", 32'(div_stall), 32'd0);
    tick();

    drive(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    tick();
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFFA);
    drive(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    tick();
    check("multu_hi", hi_o, 32'h0000_0002);
    check("multu_lo", lo_o, 32'hFFFF_FFFA);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    run_div(3'd4, 32'd100, 32'd7, cyc);
    check("divu_stall_cycles", 32'(cyc), 32'd33);
    check("divu_lo", lo_o, 32'd14);
    check("divu_hi", hi_o, 32'd2);
    check("divu_done_busy", 32'(div_busy), 32'd0);
    // back-to-back: next divide presented during DONE starts from IDLE
    drive(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    tick();
    run_div(3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_b2b_cycles", 32'(cyc), 32'd33);
    check("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    check("div_neg_hi", hi_o, 32'hFFFF_FFFF);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    run_div(3'd4, 32'h0000_1234, 32'd0, cyc);
    check("divu0_cycles", 32'(cyc), 32'd33);
    check("divu0_lo", lo_o, 32'hFFFF_FFFF);
    check("divu0_hi", hi_o, 32'h0000_1234);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    run_div(3'd3, 32'hFFFF_FFFB, 32'd0, cyc);
    check("div0_lo", lo_o, 32'hFFFF_FFFF);
    check("div0_hi", hi_o, 32'hFFFF_FFFB);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    run_div(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("div_min_lo", lo_o, 32'h8000_0000);
    check("div_min_hi", hi_o, 32'd0);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    run_div(3'd3, 32'd7, 32'hFFFF_FFFE, cyc);
    check("div_negb_lo", lo_o, 32'hFFFF_FFFD);
    check("div_negb_hi", hi_o, 32'd1);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    drive(3'd5, 32'h0000_AAAA, 32'd0, 1'b0, 1'b0);
    tick();
    drive(3'd6, 32'h0000_5555, 32'd0, 1'b0, 1'b0);
    tick();
    drive(3'd3, 32'd50, 32'd5, 1'b0, 1'b0);
    tick();
    repeat (10) tick();
    check("abort_busy_before", 32'(div_busy), 32'd1);
    flushE = 1'b1;
    #1;
    check("abort_stall_drop", 32'(div_stall), 32'd0);
    tick();
    check("abort_busy_after", 32'(div_busy), 32'd0);
    check("abort_hi", hi_o, 32'h0000_AAAA);
    check("abort_lo", lo_o, 32'h0000_5555);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    drive(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    tick();
    tick();
    check("mthi_stalled", hi_o, 32'h0000_AAAA);
    stallE = 1'b0;
    tick();
    check("mthi_released", hi_o, 32'hDEAD_BEEF);
    drive(3'd1, 32'd5, 32'd5, 1'b1, 1'b0);
    tick();
    check("mult_flushed_hi", hi_o, 32'hDEAD_BEEF);
    check("mult_flushed_lo", lo_o, 32'h0000_5555);

    drive(3'd3, 32'd10, 32'd3, 1'b1, 1'b0);
    #1;
    check("flush_div_idle_stall", 32'(div_stall), 32'd0);
    tick();
    check("flush_div_idle_busy", 32'(div_busy), 32'd0);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    drive(3'd4, 32'd1000, 32'd3, 1'b0, 1'b0);
    tick();
    stallE = 1'b1;
    repeat (32) tick();
    check("run_stalle_lo", lo_o, 32'd333);
    check("run_stalle_hi", hi_o, 32'd1);
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    drive(3'd4, 32'd1000, 32'd3, 1'b0, 1'b0);
    tick();
    repeat (5) tick();
    #2;
    rst = 1'b0;
    drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check("rst_mid_hi", hi_o, 32'd0);
    check("rst_mid_lo", lo_o, 32'd0);
    check("rst_mid_busy", 32'(div_busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
